// File: rtl/port_in_debounce.sv
// Per-bit synchronize-and-debounce input port with sticky edge flags, mask and interrupt.
// Optional falling-edge flags are built when PORTI_FALLING_EDGE_EN is defined.
module port_in_debounce #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEB_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    input  logic             tick,
    input  logic [1:0]       addr,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] stable,
    output logic             irq
);

    localparam int unsigned CNT_W = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_LEN - 1);

    logic [WIDTH-1:0]            sync1_q;
    logic [WIDTH-1:0]            sync2_q;
    logic [WIDTH-1:0]            stable_q;
    logic [WIDTH-1:0]            stable_d;
    logic [WIDTH-1:0]            rise_q;
    logic [WIDTH-1:0]            rise_d;
    logic [WIDTH-1:0]            mask_q;
    logic [WIDTH-1:0]            mask_d;
    logic [WIDTH-1:0]            fall_vis;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0]            differ;
    logic [WIDTH-1:0]            at_max;
    logic [WIDTH-1:0]            flip;
    logic [WIDTH-1:0]            set_rise;
    logic                        irq_q;
    logic                        irq_d;
    logic                        wr_rise;
    logic                        wr_mask;

    // Per-bit run counter: any agreeing tick restarts it, the DEB_LEN-th differing tick flips the bit.
    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
        assign differ[g] = sync2_q[g] ^ stable_q[g];
        assign at_max[g] = (cnt_q[g] == CNT_MAX);
        assign flip[g]   = tick & differ[g] & at_max[g];
        assign cnt_d[g]  = !tick                    ? cnt_q[g] :
                           (!differ[g] || at_max[g]) ? '0       :
                                                       cnt_q[g] + CNT_W'(1);
    end

    assign stable_d = stable_q ^ flip;
    assign set_rise = flip & sync2_q;

    assign wr_rise = wr && (addr == 2'd1);
    assign wr_mask = wr && (addr == 2'd3);

    // Sticky flags: a set in the same cycle as its write-1-clear wins.
    assign rise_d = (rise_q & ~(wr_rise ? wdata : '0)) | set_rise;
    assign mask_d = wr_mask ? wdata : mask_q;
    assign irq_d  = |((rise_q | fall_vis) & mask_q);

`ifdef PORTI_FALLING_EDGE_EN
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic             wr_fall;

    assign wr_fall  = wr && (addr == 2'd2);
    assign fall_d   = (fall_q & ~(wr_fall ? wdata : '0)) | (flip & ~sync2_q);
    assign fall_vis = fall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fall_q <= '0;
        end else begin
            fall_q <= fall_d;
        end
    end
`else
    assign fall_vis = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            rise_q   <= '0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            mask_q   <= mask_d;
            irq_q    <= irq_d;
        end
    end

    // Combinational register read.
    always_comb begin
        rdata = '0;
        case (addr)
            2'd0:    rdata = stable_q;
            2'd1:    rdata = rise_q;
            2'd2:    rdata = fall_vis;
            default: rdata = mask_q;
        endcase
    end

    assign stable = stable_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_port_in_debounce.sv
// Directed plus randomized bench for port_in_debounce against a run-length reference model.
module tb_port_in_debounce;

    localparam int unsigned W   = 32;
    localparam int          DEB = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] raw;
    logic         tick;
    logic [1:0]   addr;
    logic         wr;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    logic [W-1:0] stable;
    logic         irq;

    int total = 0;
    int bad   = 0;

    // Reference state: raw delayed two clocks, accepted levels, flags, and per-bit differing-run length.
    logic [W-1:0] m_s1, m_s2, m_st, m_rise, m_fall, m_mask;
    logic         m_irq;
    int           m_rl [W];

    port_in_debounce #(.WIDTH(W), .DEB_LEN(DEB)) dut (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw),
        .tick   (tick),
        .addr   (addr),
        .wr     (wr),
        .wdata  (wdata),
        .rdata  (rdata),
        .stable (stable),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return m_st;
            2'd1:    return m_rise;
            2'd2:    return m_fall;
            default: return m_mask;
        endcase
    endfunction

    // One clock: advance the model from the current inputs, then compare after the edge.
    task automatic step();
        logic [W-1:0] n_s1, n_s2, n_st, n_r, n_f, n_m;
        logic         n_irq;
        int           n_rl [W];
        if (reset) begin
            n_s1 = '0; n_s2 = '0; n_st = '0; n_r = '0; n_f = '0; n_m = '0; n_irq = 1'b0;
            for (int i = 0; i < int'(W); i++) n_rl[i] = 0;
        end else begin
            n_s1 = raw; n_s2 = m_s1; n_st = m_st; n_r = m_rise; n_f = m_fall; n_m = m_mask;
            n_rl = m_rl;
            n_irq = |((m_rise | m_fall) & m_mask);
            if (wr) begin
                if (addr == 2'd1) n_r = n_r & ~wdata;
`ifdef PORTI_FALLING_EDGE_EN
                if (addr == 2'd2) n_f = n_f & ~wdata;
`endif
                if (addr == 2'd3) n_m = wdata;
            end
            if (tick) begin
                for (int i = 0; i < int'(W); i++) begin
                    if (m_s2[i] != m_st[i]) begin
                        n_rl[i] = n_rl[i] + 1;
                        if (n_rl[i] == DEB) begin
                            n_st[i] = m_s2[i];
                            n_rl[i] = 0;
                            if (m_s2[i]) n_r[i] = 1'b1;
`ifdef PORTI_FALLING_EDGE_EN
                            else n_f[i] = 1'b1;
`endif
                        end
                    end else begin
                        n_rl[i] = 0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        m_s1 = n_s1; m_s2 = n_s2; m_st = n_st; m_rise = n_r; m_fall = n_f; m_mask = n_m;
        m_irq = n_irq; m_rl = n_rl;
        chk("stable", stable, m_st);
        chk("irq", W'(irq), W'(m_irq));
        chk("rdata", rdata, exp_rd(addr));
        wr   = 1'b0;
        tick = 1'b0;
    endtask

    task automatic do_tick();
        repeat (9) step();
        tick = 1'b1;
        step();
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [W-1:0] d);
        addr = a; wdata = d; wr = 1'b1;
        step();
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [W-1:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    initial begin
        reset = 1'b1; raw = '0; tick = 1'b0; addr = 2'd0; wr = 1'b0; wdata = '0;
        m_s1 = '0; m_s2 = '0; m_st = '0; m_rise = '0; m_fall = '0; m_mask = '0; m_irq = 1'b0;
        for (int i = 0; i < int'(W); i++) m_rl[i] = 0;
        repeat (3) step();
        reset = 1'b0;
        rd_chk("rst_stable", 2'd0, '0);
        rd_chk("rst_rise", 2'd1, '0);
        rd_chk("rst_fall", 2'd2, '0);
        rd_chk("rst_mask", 2'd3, '0);

        // Basic rise
        raw = 32'h4;
        repeat (3) do_tick();
        chk("rise_3ticks", stable, 32'h0);
        do_tick();
        chk("rise_4ticks", stable, 32'h4);
        rd_chk("rise_flag", 2'd1, 32'h4);
        chk("rise_irq_masked", W'(irq), 32'h0);

        // Interrupt path: mask, then clear
        reg_write(2'd3, 32'h4);
        chk("irq_mask_edge", W'(irq), 32'h0);
        step();
        chk("irq_set", W'(irq), 32'h1);
        reg_write(2'd1, 32'h4);
        rd_chk("irq_rise_clr", 2'd1, 32'h0);
        step();
        chk("irq_clr", W'(irq), 32'h0);

        // Release
        raw = 32'h0;
        repeat (3) do_tick();
        chk("rel_3ticks", stable, 32'h4);
        do_tick();
        chk("rel_4ticks", stable, 32'h0);
`ifdef PORTI_FALLING_EDGE_EN
        rd_chk("rel_fall", 2'd2, 32'h4);
`else
        rd_chk("rel_fall", 2'd2, 32'h0);
`endif
        reg_write(2'd2, 32'h4);
        rd_chk("fall_clr", 2'd2, 32'h0);
        step();

        // Set/clear race on rise bit 2
        raw = 32'h4;
        repeat (3) do_tick();
        repeat (9) step();
        tick = 1'b1; addr = 2'd1; wdata = 32'h4; wr = 1'b1;
        step();
        rd_chk("race_rise", 2'd1, 32'h4);
        reg_write(2'd1, 32'h4);
        step();

        // Glitch rejection on bit 0
        raw = 32'h5;
        repeat (3) do_tick();
        raw = 32'h4;
        do_tick();
        raw = 32'h5;
        repeat (3) do_tick();
        chk("glitch_3ticks", stable, 32'h4);
        do_tick();
        chk("glitch_4ticks", stable, 32'h5);

        // Reset mid-count, then a bit held high through release
        raw = 32'h1;
        repeat (2) do_tick();
        reset = 1'b1; addr = 2'd3;
        step();
        reset = 1'b0;
        chk("midrst_stable", stable, 32'h0);
        chk("midrst_irq", W'(irq), 32'h0);
        rd_chk("midrst_rise", 2'd1, 32'h0);
        rd_chk("midrst_mask", 2'd3, 32'h0);
        repeat (3) do_tick();
        chk("post_rst_3ticks", stable, 32'h0);
        do_tick();
        chk("post_rst_4ticks", stable, 32'h1);
        rd_chk("post_rst_rise", 2'd1, 32'h1);

        // Continuous tick with slowly changing inputs
        reg_write(2'd3, 32'hffff_ffff);
        for (int n = 0; n < 60; n++) begin
            tick = 1'b1;
            addr = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) raw = raw ^ (W'(1) << $urandom_range(0, W - 1));
            step();
        end

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            tick  = ($urandom_range(0, 2) == 0);
            addr  = 2'($urandom_range(0, 3));
            wr    = ($urandom_range(0, 7) == 0);
            wdata = $urandom;
            if ($urandom_range(0, 5) == 0) raw = raw ^ (W'(1) << $urandom_range(0, W - 1));
            if ($urandom_range(0, 3) == 0) raw[0] = ~raw[0];
            step();
        end
        reset = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
